rv32i_memory_responder: RTL and testbench

- Single-port memory responder on the far side of the multicycle RV32I core's memory interface: accepts mem_addr/mem_wr_data/mem_wr_ena and returns mem_rd_data.
- Decodes a word-addressed RAM region and a small MMIO region: LEDs, a 64-bit cycle counter with hi-word snapshot, and a scratch register.
- Flags illegal accesses with a sticky fault.
- Sits at the top level between the core and the board pins.

---
 rtl/rv32i_mem_map_pkg.sv | 33 +++
 rtl/mmio_cycle_counter.sv | 28 ++
 rtl/rv32i_memory_responder.sv | 133 +++++++++++++
 tb/tb_rv32i_memory_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_map_pkg.sv
// Memory map for the RV32I memory responder: MMIO offsets,
// region enum and the address region decoder.
package rv32i_mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hF000_0000;

  localparam logic [3:0] LED_OFF      = 4'h0;
  localparam logic [3:0] CYCLE_LO_OFF = 4'h4;
  localparam logic [3:0] CYCLE_HI_OFF = 4'h8;
  localparam logic [3:0] SCRATCH_OFF  = 4'hC;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } mem_region_t;

  function automatic mem_region_t decode_region(
    input logic [31:0] addr,
    input int unsigned ram_words,
    input logic [31:0] mmio_base = MMIO_BASE_DEFAULT
  );
    logic [31:0] lim;
    logic [31:0] rel;
    lim = ram_words * 32'd4;
    // Relative compare so a base near the top of memory cannot overflow.
    rel = addr - mmio_base;
    if (addr < lim) return REGION_RAM;
    if (rel < 32'd16) return REGION_MMIO;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/mmio_cycle_counter.sv
// Free-running 64-bit cycle counter with a hi-word snapshot
// taken whenever the low word is read.
module mmio_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        snap,
  output logic [31:0] count_lo,
  output logic [31:0] hi_snap
);

  logic [63:0] r_count;
  logic [31:0] r_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_hi    <= '0;
    end else if (ena) begin
      r_count <= r_count + 64'd1;
      if (snap) r_hi <= r_count[63:32];
    end
  end

  assign count_lo = r_count[31:0];
  assign hi_snap  = r_hi;

endmodule

// File: rtl/rv32i_memory_responder.sv
// Word RAM plus LED/cycle/scratch MMIO with sticky fault capture.
// Define MMIO_COUNTER_EN to build the cycle counter registers.
module rv32i_memory_responder
  import rv32i_mem_map_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  leds,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];

  logic [31:0] r_rd_data;
  logic [7:0]  r_leds;
  logic [31:0] r_scratch;
  logic        r_fault;
  logic [31:0] r_fault_addr;

  mem_region_t w_region;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_off;
  logic        w_is_mmio;
  logic        w_cnt_reg;
  logic        w_unmapped;
  logic        w_fault;
  logic        w_ok;
  logic        w_ram_we;
  logic        w_mmio_we;
  logic [31:0] w_rd_next;

  assign w_region  = decode_region(mem_addr, RAM_WORDS, MMIO_BASE);
  assign w_idx     = mem_addr[AW+1:2];
  assign w_off     = mem_addr[3:0] - MMIO_BASE[3:0];
  assign w_is_mmio = (w_region == REGION_MMIO);
  assign w_cnt_reg = w_is_mmio &&
                     ((w_off == CYCLE_LO_OFF) ||
                      (w_off == CYCLE_HI_OFF));

`ifdef MMIO_COUNTER_EN
  logic        w_snap;
  logic [31:0] w_count_lo;
  logic [31:0] w_hi_snap;

  assign w_unmapped = 1'b0;
  assign w_snap     = w_ok && w_is_mmio &&
                      (w_off == CYCLE_LO_OFF);

  mmio_cycle_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .snap     (w_snap),
    .count_lo (w_count_lo),
    .hi_snap  (w_hi_snap)
  );
`else
  assign w_unmapped = w_cnt_reg;
`endif

  assign w_fault = (|mem_addr[1:0]) ||
                   (w_region == REGION_NONE) ||
                   w_unmapped;
  assign w_ok    = ena && !w_fault;

  // A write racing an asserting reset is dropped.
  assign w_ram_we  = w_ok && mem_wr_ena && !rst &&
                     (w_region == REGION_RAM);
  assign w_mmio_we = w_ok && mem_wr_ena && w_is_mmio;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_idx] <= mem_wr_data;
  end

  always_comb begin
    w_rd_next = '0;
    if (!w_fault) begin
      unique case (w_region)
        REGION_RAM: w_rd_next = r_ram[w_idx];
        REGION_MMIO: begin
          unique case (w_off)
            LED_OFF:      w_rd_next = {24'b0, r_leds};
`ifdef MMIO_COUNTER_EN
            CYCLE_LO_OFF: w_rd_next = w_count_lo;
            CYCLE_HI_OFF: w_rd_next = w_hi_snap;
`endif
            SCRATCH_OFF:  w_rd_next = r_scratch;
            default:      w_rd_next = '0;
          endcase
        end
        default: w_rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data    <= '0;
      r_leds       <= '0;
      r_scratch    <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (ena) begin
      r_rd_data <= w_rd_next;
      if (w_mmio_we && (w_off == LED_OFF))
        r_leds <= mem_wr_data[7:0];
      if (w_mmio_we && (w_off == SCRATCH_OFF))
        r_scratch <= mem_wr_data;
      if (w_fault && !r_fault) begin
        r_fault      <= 1'b1;
        r_fault_addr <= mem_addr;
      end
    end
  end

  assign mem_rd_data = r_rd_data;
  assign leds        = r_leds;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_rv32i_memory_responder.sv
// Randomized self-checking bench for rv32i_memory_responder.
module tb_rv32i_memory_responder;

  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] MMIO      = 32'hF000_0000;
`ifdef MMIO_COUNTER_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        mem_wr_ena = 1'b0;
  logic [31:0] mem_rd_data;
  logic [7:0]  leds;
  logic        fault;
  logic [31:0] fault_addr;

  rv32i_memory_responder #(
    .RAM_WORDS (RAM_WORDS),
    .INIT_FILE (""),
    .MMIO_BASE (MMIO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .leds        (leds),
    .fault       (fault),
    .fault_addr  (fault_addr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_ram [int];
  logic [7:0]  m_leds;
  logic [31:0] m_scratch;
  logic [31:0] m_hi;
  logic [31:0] m_rd;
  logic        m_fault;
  logic [31:0] m_fault_addr;
  logic [63:0] m_cycle;

  function automatic void model_reset();
    m_leds = '0; m_scratch = '0; m_hi = '0; m_rd = '0;
    m_fault = 1'b0; m_fault_addr = '0; m_cycle = '0;
  endfunction

  task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic en);
    logic [31:0] rel;
    logic in_ram, in_mmio, flt;
    int w;
    mem_addr = a; mem_wr_data = d; mem_wr_ena = we; ena = en;
    if (en) begin
      in_ram  = a < RAM_WORDS * 4;
      rel     = a - MMIO;
      in_mmio = rel < 16;
      w       = int'(rel >> 2);
      flt = (a % 4 != 0) || (!in_ram && !in_mmio) ||
            (in_mmio && !HAS_CNT && (w == 1 || w == 2));
      if (flt) begin
        m_rd = 0;
        if (!m_fault) m_fault_addr = a;
        m_fault = 1'b1;
      end else if (in_ram) begin
        m_rd = m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'h0;
        if (we) m_ram[int'(a >> 2)] = d;
      end else begin
        case (w)
          0: begin m_rd = {24'b0, m_leds}; if (we) m_leds = d[7:0]; end
          1: begin m_rd = m_cycle[31:0]; m_hi = m_cycle[63:32]; end
          2: m_rd = m_hi;
          default: begin m_rd = m_scratch; if (we) m_scratch = d; end
        endcase
      end
      m_cycle = m_cycle + 64'd1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; mem_wr_ena = 1'b1; mem_addr = MMIO;
    mem_wr_data = 32'hFF;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (mem_rd_data !== 32'h0) $display("FAIL reset_rd got %h want 0", mem_rd_data);
    else n_pass++;
    n_total++;
    if (leds !== 8'h0) $display("FAIL reset_leds got %h want 0", leds);
    else n_pass++;
    n_total++;
    if (fault !== 1'b0 || fault_addr !== 32'h0)
      $display("FAIL reset_fault got %b/%h want 0/0", fault, fault_addr);
    else n_pass++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_ram_rw();
    cyc(32'h0, 32'h0000_AAAA, 1, 1);
    cyc(32'h20, 32'h1111_1111, 1, 1);
    cyc(32'h40, 32'h0BAD_F00D, 1, 1);
    for (int k = 0; k < 16; k++) cyc(32'h100 + 4 * k, $urandom, 1, 1);
    cyc(32'h10, 32'hDEAD_BEEF, 1, 1);
    cyc(32'h10, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'hDEAD_BEEF || fault !== 1'b0)
      $display("FAIL ram_rw got %h/%b want deadbeef/0", mem_rd_data, fault);
    else n_pass++;
  endtask

  task automatic test_read_first();
    cyc(32'h20, 32'h2222_2222, 1, 1);
    n_total++;
    if (mem_rd_data !== 32'h1111_1111)
      $display("FAIL read_first_old got %h want 11111111", mem_rd_data);
    else n_pass++;
    cyc(32'h20, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h2222_2222)
      $display("FAIL read_first_new got %h want 22222222", mem_rd_data);
    else n_pass++;
  endtask

  task automatic test_led_scratch();
    logic [63:0] c0;
    cyc(MMIO, 32'h0000_01A5, 1, 1);
    n_total++;
    if (leds !== 8'hA5) $display("FAIL led_write got %h want a5", leds);
    else n_pass++;
    cyc(MMIO, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h0000_00A5)
      $display("FAIL led_read got %h want 000000a5", mem_rd_data);
    else n_pass++;
    cyc(MMIO + 32'hC, 32'hC0FF_EE01, 1, 1);
    cyc(MMIO + 32'hC, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'hC0FF_EE01)
      $display("FAIL scratch got %h want c0ffee01", mem_rd_data);
    else n_pass++;
    if (HAS_CNT) begin
      c0 = m_cycle;
      cyc(MMIO + 32'h4, 32'hFFFF_FFFF, 1, 1);
      n_total++;
      if (mem_rd_data !== c0[31:0] || fault !== 1'b0)
        $display("FAIL ro_write got %h/%b want %h/0", mem_rd_data, fault, c0[31:0]);
      else n_pass++;
      c0 = c0 + 64'd1;
      cyc(MMIO + 32'h4, 32'h0, 0, 1);
      n_total++;
      if (mem_rd_data !== c0[31:0])
        $display("FAIL cnt_after_ro got %h want %h", mem_rd_data, c0[31:0]);
      else n_pass++;
    end
  endtask

`ifdef MMIO_COUNTER_EN
  task automatic test_counter();
    force dut.u_cnt.r_count = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.u_cnt.r_count;
    m_cycle = 64'h0000_0000_FFFF_FFFE;
    cyc(MMIO + 32'h4, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'hFFFF_FFFE)
      $display("FAIL cnt_lo got %h want fffffffe", mem_rd_data);
    else n_pass++;
    cyc(32'h100, 32'h0, 0, 1);
    cyc(MMIO + 32'h8, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h0)
      $display("FAIL cnt_hi_snap got %h want 00000000", mem_rd_data);
    else n_pass++;
    cyc(MMIO + 32'h4, 32'h0, 0, 1);
    cyc(MMIO + 32'h8, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h1)
      $display("FAIL cnt_hi_resnap got %h want 00000001", mem_rd_data);
    else n_pass++;
  endtask
`endif

  task automatic test_faults();
    cyc(32'h0000_0002, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h0 || fault !== 1'b1 || fault_addr !== 32'h2)
      $display("FAIL fault_first got %h/%b/%h want 0/1/2",
               mem_rd_data, fault, fault_addr);
    else n_pass++;
    cyc(32'h3000_0000, 32'h5, 1, 1);
    n_total++;
    if (leds !== 8'hA5 || fault_addr !== 32'h2 || mem_rd_data !== 32'h0)
      $display("FAIL fault_oor got %h/%h/%h want a5/2/0",
               leds, fault_addr, mem_rd_data);
    else n_pass++;
    cyc(32'h0, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h0000_AAAA)
      $display("FAIL fault_no_alias got %h want 0000aaaa", mem_rd_data);
    else n_pass++;
    cyc(MMIO + 32'h4, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== m_rd || fault !== 1'b1)
      $display("FAIL fault_cnt_map got %h/%b want %h/1", mem_rd_data, fault, m_rd);
    else n_pass++;
  endtask

  task automatic test_ena();
    for (int i = 0; i < 5; i++) begin
      cyc((i % 2) ? MMIO : 32'h104, $urandom, 1, 0);
      n_total++;
      if (mem_rd_data !== m_rd || leds !== m_leds)
        $display("FAIL ena_hold[%0d] got %h/%h want %h/%h",
                 i, mem_rd_data, leds, m_rd, m_leds);
      else n_pass++;
    end
    cyc(32'h104, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== m_rd)
      $display("FAIL ena_ram got %h want %h", mem_rd_data, m_rd);
    else n_pass++;
    if (HAS_CNT) begin
      cyc(MMIO + 32'h4, 32'h0, 0, 1);
      n_total++;
      if (mem_rd_data !== m_rd)
        $display("FAIL ena_cnt got %h want %h", mem_rd_data, m_rd);
      else n_pass++;
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)       a = 32'h100 + 4 * $urandom_range(0, 15);
      else if (sel < 8)  a = MMIO + 4 * $urandom_range(0, 3);
      else if (sel == 8) a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else               a = 32'h400 + 4 * $urandom_range(0, 100);
      cyc(a, $urandom, 1'($urandom), $urandom_range(0, 7) != 0);
      n_total++;
      if (mem_rd_data !== m_rd || leds !== m_leds ||
          fault !== m_fault || fault_addr !== m_fault_addr)
        $display("FAIL random[%0d] a=%h got %h/%h/%b/%h want %h/%h/%b/%h",
                 i, a, mem_rd_data, leds, fault, fault_addr,
                 m_rd, m_leds, m_fault, m_fault_addr);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    mem_addr = 32'h40; mem_wr_data = 32'hCAFE_0000;
    mem_wr_ena = 1'b1; ena = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (mem_rd_data !== 32'h0 || leds !== 8'h0 ||
        fault !== 1'b0 || fault_addr !== 32'h0)
      $display("FAIL reset_async got %h/%h/%b/%h want all 0",
               mem_rd_data, leds, fault, fault_addr);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc(32'h40, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h0BAD_F00D)
      $display("FAIL reset_lost_write got %h want 0badf00d", mem_rd_data);
    else n_pass++;
    cyc(MMIO + 32'hC, 32'h0, 0, 1);
    n_total++;
    if (mem_rd_data !== 32'h0)
      $display("FAIL reset_scratch got %h want 0", mem_rd_data);
    else n_pass++;
    if (HAS_CNT) begin
      cyc(MMIO + 32'h4, 32'h0, 0, 1);
      n_total++;
      if (mem_rd_data !== 32'h2)
        $display("FAIL reset_cnt got %h want 00000002", mem_rd_data);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ram_rw();
    test_read_first();
    test_led_scratch();
`ifdef MMIO_COUNTER_EN
    test_counter();
`endif
    test_faults();
    test_ena();
    test_random(300);
    test_reset_mid();
    test_random(100);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
